// File: rtl/spi_mult_pkg.sv
// Shared encodings for the SPI multiplier peripheral: shift-register modes
// and the sequencer state codes.
package spi_mult_pkg;

  typedef logic [1:0] sr_mode_t;

  localparam sr_mode_t MODE_HOLD  = 2'b00;
  localparam sr_mode_t MODE_SHIFT = 2'b01;
  localparam sr_mode_t MODE_LOAD  = 2'b10;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_RECV      = 3'd1;
  localparam state_t ST_START     = 3'd2;
  localparam state_t ST_WAIT_MULT = 3'd3;
  localparam state_t ST_LOAD      = 3'd4;
  localparam state_t ST_SEND      = 3'd5;
  localparam state_t ST_FINISH    = 3'd6;

endpackage

// File: rtl/spi_bit_counter.sv
// Loadable up-counter that saturates at MAX. tc flags that the next enabled
// increment lands on MAX, so the caller can act on the same cycle as that event.
module spi_bit_counter #(
  parameter int MAX   = 8,
  parameter int WIDTH = $clog2(MAX) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] LAST_V = WIDTH'(MAX - 1);

  logic [WIDTH-1:0] count;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every always_ff reads the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && count != MAX_V) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == LAST_V);

endmodule

// File: rtl/spi_mult_sequencer.sv
// Frame sequencer: receive an operand byte, run the multiplier, load the
// product into the shift register and shift it out, with abort and timeout.
module spi_mult_sequencer
  import spi_mult_pkg::*;
#(
  parameter int NBITS   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic       sclk_posedge,
  input  logic       sclk_negedge,
  input  logic       mult_done,
  output logic [1:0] sr_mode,
  output logic       mult_start,
  output logic       miso_en,
  output logic       busy,
  output logic       timeout_err
);

  state_t state_q, state_d;
  logic   bit_clr, bit_en, bit_tc;
  logic   wait_clr, wait_en, wait_tc;
  logic   set_err, clr_err;

  spi_bit_counter #(.MAX(NBITS)) u_bit_cnt (
    .clk      (clk),
    .reset    (reset),
    .clr      (bit_clr),
    .load     (1'b0),
    .load_val ('0),
    .en       (bit_en),
    .tc       (bit_tc)
  );

  // Saturates at TIMEOUT-1; reaching that value without done is the timeout.
  spi_bit_counter #(.MAX(TIMEOUT - 1)) u_wait_cnt (
    .clk      (clk),
    .reset    (reset),
    .clr      (wait_clr),
    .load     (1'b0),
    .load_val ('0),
    .en       (wait_en),
    .tc       (wait_tc)
  );

  // NOTE: every signal driven here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d  = state_q;
    sr_mode  = MODE_HOLD;
    bit_clr  = 1'b0;
    bit_en   = 1'b0;
    wait_clr = 1'b0;
    wait_en  = 1'b0;
    set_err  = 1'b0;
    clr_err  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        bit_clr = 1'b1;
        if (!cs) begin
          state_d = ST_RECV;
          clr_err = 1'b1;
        end
      end
      ST_RECV: begin
        // cs high wins over a coincident final edge: no shift, straight abort.
        if (cs) begin
          state_d = ST_IDLE;
        end else if (sclk_posedge) begin
          sr_mode = MODE_SHIFT;
          bit_en  = 1'b1;
          if (bit_tc) state_d = ST_START;
        end
      end
      ST_START: begin
        wait_clr = 1'b1;
        state_d  = cs ? ST_IDLE : ST_WAIT_MULT;
      end
      ST_WAIT_MULT: begin
        wait_en = 1'b1;
        if (cs) begin
          state_d = ST_IDLE;
        end else if (mult_done) begin
          state_d = ST_LOAD;
        end else if (wait_tc) begin
          state_d = ST_FINISH;
          set_err = 1'b1;
        end
      end
      ST_LOAD: begin
        bit_clr = 1'b1;
        if (cs) begin
          state_d = ST_IDLE;
        end else begin
          sr_mode = MODE_LOAD;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (cs) begin
          state_d = ST_IDLE;
        end else if (sclk_negedge) begin
          sr_mode = MODE_SHIFT;
          bit_en  = 1'b1;
          if (bit_tc) state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        if (cs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: reset is synchronous and outranks every other event in the cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      miso_en     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_q <= state_d;
      miso_en <= (state_d == ST_SEND);
      if (set_err) begin
        timeout_err <= 1'b1;
      end else if (clr_err) begin
        timeout_err <= 1'b0;
      end
    end
  end

  assign mult_start = (state_q == ST_START);
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_mult_sequencer.sv
// Randomized frame-level bench for spi_mult_sequencer; expectations are derived
// from the cycle numbers of the edges and handshakes the bench itself drives.
module tb_spi_mult_sequencer;

  localparam int NBITS   = 8;
  localparam int TIMEOUT = 64;

  logic       clk = 1'b0;
  logic       reset, cs, sclk_posedge, sclk_negedge, mult_done;
  logic [1:0] sr_mode;
  logic       mult_start, miso_en, busy, timeout_err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Observed activity since the last clear_stats
  int n_shift, n_load, n_start, n_miso;
  int start_cyc, load_cyc, miso_first, miso_last, err_cyc;

  always #5 clk = ~clk;

  spi_mult_sequencer #(.NBITS(NBITS), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .cs           (cs),
    .sclk_posedge (sclk_posedge),
    .sclk_negedge (sclk_negedge),
    .mult_done    (mult_done),
    .sr_mode      (sr_mode),
    .mult_start   (mult_start),
    .miso_en      (miso_en),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clear_stats();
    n_shift = 0; n_load = 0; n_start = 0; n_miso = 0;
    start_cyc = -1; load_cyc = -1; miso_first = -1; miso_last = -1; err_cyc = -1;
  endtask

  // One clock: sample outputs mid-cycle, advance, then drop the edge pulses.
  task automatic tick();
    @(negedge clk);
    if (sr_mode == 2'b01) n_shift++;
    if (sr_mode == 2'b10) begin n_load++; load_cyc = cyc; end
    if (mult_start) begin n_start++; start_cyc = cyc; end
    if (miso_en) begin
      n_miso++;
      if (miso_first < 0) miso_first = cyc;
      miso_last = cyc;
    end
    if (timeout_err && err_cyc < 0) err_cyc = cyc;
    @(posedge clk);
    cyc++;
    #1;
    sclk_posedge = 1'b0;
    sclk_negedge = 1'b0;
  endtask

  // n SCLK rises with random gaps; stray falls in the gaps must not shift.
  task automatic recv_bits(input int n, output int last_cyc);
    last_cyc = -1;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) begin
        sclk_negedge = ($urandom_range(0, 1) == 1);
        tick();
      end
      sclk_posedge = 1'b1;
      sclk_negedge = ($urandom_range(0, 3) == 0);
      last_cyc = cyc;
      tick();
    end
  endtask

  // n SCLK falls with random gaps; stray rises in the gaps must not shift.
  task automatic send_bits(input int n, output int last_cyc);
    last_cyc = -1;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) begin
        sclk_posedge = ($urandom_range(0, 1) == 1);
        tick();
      end
      sclk_negedge = 1'b1;
      sclk_posedge = ($urandom_range(0, 3) == 0);
      last_cyc = cyc;
      tick();
    end
  endtask

  // Receive NBITS, wait d cycles for done, load, send NBITS, finish, release cs.
  task automatic run_frame();
    int p, dc, nl, d;
    clear_stats();
    cs = 1'b0;
    tick();
    recv_bits(NBITS, p);
    tick();
    d = $urandom_range(0, 20);
    repeat (d) tick();
    mult_done = 1'b1;
    dc = cyc;
    tick();
    tick();
    send_bits(NBITS, nl);
    repeat ($urandom_range(1, 3)) begin
      sclk_posedge = 1'b1;
      sclk_negedge = 1'b1;
      tick();
    end
    mult_done = 1'b0;
    cs = 1'b1;
    tick();
    check("frame_shifts", n_shift, 2 * NBITS);
    check("frame_starts", n_start, 1);
    check("frame_start_lat", start_cyc, p + 1);
    check("frame_loads", n_load, 1);
    check("frame_load_lat", load_cyc, dc + 1);
    check("frame_miso_first", miso_first, dc + 2);
    check("frame_miso_last", miso_last, nl);
    check("frame_miso_cycles", n_miso, nl - dc - 1);
    check("frame_busy_end", busy, 0);
    check("frame_err", timeout_err, 0);
  endtask

  initial begin
    int p, nl, dc, ab;
    reset = 1'b1; cs = 1'b1; sclk_posedge = 1'b0; sclk_negedge = 1'b0; mult_done = 1'b0;
    clear_stats();
    repeat (3) tick();
    check("rst_sr_mode", sr_mode, 0);
    check("rst_mult_start", mult_start, 0);
    check("rst_miso_en", miso_en, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout_err", timeout_err, 0);
    reset = 1'b0;
    tick();

    repeat (4) run_frame();

    // Multiplier never answers
    clear_stats();
    cs = 1'b0;
    tick();
    recv_bits(NBITS, p);
    repeat (TIMEOUT + 6) tick();
    check("to_starts", n_start, 1);
    check("to_err_cycle", err_cyc, p + 1 + TIMEOUT);
    check("to_miso", n_miso, 0);
    check("to_loads", n_load, 0);
    check("to_busy_finish", busy, 1);
    cs = 1'b1;
    tick();
    check("to_sticky", timeout_err, 1);
    check("to_idle", busy, 0);
    cs = 1'b0;
    tick();
    check("to_cleared", timeout_err, 0);
    check("to_new_frame", busy, 1);
    cs = 1'b1;
    tick();

    // Abort after 3 rises, then a full frame must count from bit 0
    clear_stats();
    cs = 1'b0;
    tick();
    recv_bits(3, p);
    cs = 1'b1;
    tick();
    check("abr_recv_busy", busy, 0);
    repeat (2) tick();
    check("abr_recv_starts", n_start, 0);
    check("abr_recv_shifts", n_shift, 3);
    run_frame();

    // Abort after 4 falls, with a coincident fall that must not shift
    clear_stats();
    cs = 1'b0;
    tick();
    recv_bits(NBITS, p);
    tick();
    mult_done = 1'b1;
    dc = cyc;
    tick();
    tick();
    send_bits(4, nl);
    cs = 1'b1;
    sclk_negedge = 1'b1;
    ab = cyc;
    tick();
    mult_done = 1'b0;
    check("abr_send_miso", miso_en, 0);
    check("abr_send_busy", busy, 0);
    check("abr_send_shifts", n_shift, NBITS + 4);
    check("abr_send_miso_cycles", n_miso, ab - dc - 1);
    tick();

    // Reset while waiting for the multiplier
    cs = 1'b0;
    tick();
    recv_bits(NBITS, p);
    repeat (6) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_sr_mode", sr_mode, 0);
    check("mid_rst_mult_start", mult_start, 0);
    check("mid_rst_miso_en", miso_en, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_err", timeout_err, 0);
    clear_stats();
    cs = 1'b1;
    mult_done = 1'b1;
    tick();
    mult_done = 1'b0;
    repeat (3) tick();
    check("mid_rst_done_ignored", n_load, 0);
    check("mid_rst_no_miso", n_miso, 0);
    check("mid_rst_idle", busy, 0);

    // cs rises together with the final rise
    clear_stats();
    cs = 1'b0;
    tick();
    recv_bits(NBITS - 1, p);
    cs = 1'b1;
    sclk_posedge = 1'b1;
    tick();
    check("corner_busy", busy, 0);
    repeat (3) tick();
    check("corner_shifts", n_shift, NBITS - 1);
    check("corner_starts", n_start, 0);

    run_frame();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_mult_sequencer.md
Name: spi_mult_sequencer

Overview:
Sequencing controller for the SPI multiplier peripheral. It watches the conditioned chip-select and SCLK edge pulses and drives the 8-bit shift register's mode and the 4x4 multiplier's start. Each CS-low frame receives one operand byte, runs the multiplier, loads the 8-bit product into the shift register and gates it out on MISO. It replaces the ad-hoc top-level sequencing with one synchronous FSM, adding abort and timeout handling.

Parameters:
NBITS, 8, frame length in bits; shift register and product width.
TIMEOUT, 64, max clk cycles in WAIT_MULT before timeout_err.

Ports:
clk  in  1  system clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
cs  in  1  conditioned chip select, active low.
sclk_posedge  in  1  one-clk pulse on conditioned SCLK rise.
sclk_negedge  in  1  one-clk pulse on conditioned SCLK fall.
mult_done  in  1  multiplier result valid; level, held until next start.
sr_mode  out  2  shift register mode: HOLD=00, SHIFT=01, LOAD=10.
mult_start  out  1  one-cycle multiplier start pulse.
miso_en  out  1  enables the MISO output AND gate.
busy  out  1  high in every state except IDLE.
timeout_err  out  1  sticky; set on multiplier timeout, cleared by reset or next CS fall.

Behaviour:
- Reset: state=IDLE, bit_cnt=0, wait_cnt=0, sr_mode=HOLD, mult_start=0, miso_en=0, busy=0, timeout_err=0. Reset has priority over every other event.
- States: IDLE, RECV, START, WAIT_MULT, LOAD, SEND, FINISH.
- IDLE: cs==0 -> RECV, bit_cnt=0, timeout_err cleared.
- RECV: sr_mode=SHIFT combinationally in any cycle with sclk_posedge=1, else HOLD. Each sclk_posedge increments bit_cnt. On the NBITS-th posedge -> START.
- START: mult_start=1 for exactly this one cycle. wait_cnt=0. Then -> WAIT_MULT.
- WAIT_MULT: wait_cnt increments each cycle. mult_done=1 -> LOAD. If wait_cnt reaches TIMEOUT-1 without done -> FINISH with timeout_err=1. mult_done is ignored in all other states.
- LOAD: sr_mode=LOAD for exactly one cycle. bit_cnt=0. Then -> SEND.
- SEND: miso_en=1 (registered, high from the first SEND cycle through the last). sr_mode=SHIFT in cycles with sclk_negedge=1. Each negedge increments bit_cnt. On the NBITS-th negedge -> FINISH.
- FINISH: miso_en=0, sr_mode=HOLD. Wait for cs==1, then -> IDLE. Extra SCLK edges are ignored.
- Abort: cs==1 in RECV, START, WAIT_MULT, LOAD or SEND -> IDLE on the next clk. Outputs go to reset values except timeout_err. A mult_start already issued is not retracted.
- Simultaneous events: cs rising in the same cycle as the final SCLK edge is an abort, and the final SHIFT is suppressed. sclk_posedge and sclk_negedge together are illegal: posedge wins in RECV, negedge wins in SEND.
- bit_cnt width is clog2(NBITS)+1. No wrap: it saturates at NBITS and is cleared on state entry.
- Latency: last MOSI posedge -> mult_start is 1 cycle. mult_done -> LOAD is 1 cycle. LOAD -> miso_en high is 1 cycle.

Decomposition:
- Shared package spi_mult_pkg holds the sr_mode encodings (MODE_HOLD, MODE_SHIFT, MODE_LOAD) and the state enum. The shift register and top level use the same package.
- One natural sub-module: spi_bit_counter. It is a loadable, saturating counter with clear, enable and terminal-count output, instantiated for bit_cnt and reused for wait_cnt.

Test Plan:
- Full frame: cs low, shift 0x35 MSB first, multiplier returns done after 5 cycles, product 0x0F. Expect exactly 8 SHIFT cycles in RECV, 1 mult_start, 1 LOAD, miso_en high for 8 negedges, FINISH, then IDLE after cs high.
- Timeout: mult_done held 0 with TIMEOUT=64. Expect timeout_err=1 exactly 64 cycles after mult_start and miso_en never high. The next cs fall clears timeout_err.
- Abort in RECV: cs high after 3 posedges. Expect IDLE next cycle, no mult_start, busy=0. The next frame counts from bit 0.
- Abort in SEND: cs high after 4 negedges. Expect miso_en=0 on the next cycle and IDLE.
- Reset mid-WAIT_MULT: reset=1 for 1 cycle. All outputs are at reset values on the following cycle, and a later mult_done pulse is ignored.
- Edge corner: cs rises in the same cycle as the 8th posedge. Expect no SHIFT that cycle, no mult_start, IDLE.
